jk_drive_sequencer: RTL and testbench
=====================================

# jk_drive_sequencer

Command-driven stimulus stage that sits directly upstream of the master-slave JK flip-flop and drives its J/K inputs. It accepts hold/reset/set/toggle commands with a cycle count over a valid/ready handshake and holds J/K for that many clocks. It tracks a model of the flip-flop's expected output, then samples the flip-flop's Q after the slave has settled and flags any mismatch.

## Interface
- CNT_W, 8, width of the command length field; max drive length 2^CNT_W-1 cycles
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  {J,K} encoding: 00 hold, 01 reset, 10 set, 11 toggle
- cmd_len  in  CNT_W  number of clock cycles to drive cmd_op
- J  out  1  registered J drive to the flip-flop
- K  out  1  registered K drive to the flip-flop
- q_in  in  1  Q output of the flip-flop's slave latch
- q_model  out  1  expected Q after all completed drive cycles
- busy  out  1  high in DRIVE or SETTLE
- done  out  1  one-cycle pulse when a command completes
- mismatch  out  1  one-cycle pulse, coincident with done, when q_in != q_model at check
- err_sticky  out  1  set on any mismatch; cleared only by rst

## Operation
- States: IDLE, DRIVE, SETTLE.
- IDLE: cmd_ready=1, J=K=0. Handshake completes when cmd_valid and cmd_ready are high on the same posedge.
  - cmd_len != 0: latch op, load the counter with cmd_len, go to DRIVE.
  - cmd_len == 0: no drive. Go to SETTLE directly; the check still runs against the unchanged q_model.
- DRIVE: {J,K}=op for exactly cmd_len cycles. At each posedge ending a DRIVE cycle, q_model advances.
  - Hold: q_model unchanged.
  - Reset: q_model=0.
  - Set: q_model=1.
  - Toggle: q_model inverts.
  - The counter decrements at each DRIVE posedge. At the posedge where the count reaches 1, go to SETTLE.
- SETTLE: J=K=0 for one cycle. The flip-flop's master captured the last drive at the SETTLE entry edge, and its slave updated Q at the mid-cycle negedge. At the posedge ending SETTLE, compare q_in with q_model, go to IDLE, and register done=1 and mismatch=(q_in!=q_model).
- err_sticky sets on the edge that registers mismatch=1.
- cmd_op/cmd_len are ignored outside IDLE. cmd_ready=0 in DRIVE and SETTLE, so there is no queueing.
- The flip-flop has no reset, so its Q is unknown at power-up. The first command after rst must be set or reset; a hold/toggle first command may legitimately mismatch.
- Reset, on any edge with rst=1, including mid-DRIVE or mid-SETTLE:
  - State goes to IDLE and the counter to 0.
  - J, K, q_model, done, mismatch and err_sticky go to 0.
  - cmd_ready=0 during the rst cycle.
  - An in-flight command is dropped and produces no done.

## Timing
- Accept at edge T0. J/K valid from T0 through T0+len-1 (len cycles). SETTLE is cycle T0+len. done/mismatch are high in cycle T0+len+1, and cmd_ready is high in that same cycle.
- Command-to-done latency is len+1 edges after the accept edge; len=0 gives 1.
- Back-to-back: a command may be accepted in the done cycle. Its DRIVE starts on the next edge, so the J/K gap between commands is exactly one SETTLE cycle plus the done cycle.
- Counter arithmetic is unsigned CNT_W; the counter never wraps because DRIVE exits at 1.
- Every output is registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package jk_pkg:
  - Op constants JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10, JK_TOGGLE=2'b11.
  - State type (IDLE, DRIVE, SETTLE).
  - Function jk_next(q, op) returning the JK next-state value.
- No sub-module: a single FSM plus counter, with q_model computed via jk_next.
- The bench instantiates the master-slave JK flip-flop as the downstream load on J/K/q_in.

## Test plan
- rst held 3 cycles, then released. Required: J=K=0, q_model=0, done=0, err_sticky=0, cmd_ready=0 during rst and 1 the cycle after.
- set len=1, then reset len=2. Required: set → J=1 K=0 for 1 cycle, done 2 edges after accept, q_model=1, mismatch=0. Reset → J=0 K=1 for 2 cycles, q_model=0, mismatch=0.
- reset len=1, then toggle len=5. Required: J=K=1 for 5 cycles, q_model=1, q_in=1 at check, done exactly 6 edges after accept.
- toggle len=0. Required: no J/K activity, done 1 edge after accept, q_model unchanged, mismatch=0.
- Force q_in to its inverse after set len=3. Required: mismatch=1 and done=1 same cycle, err_sticky=1 and held through subsequent good commands until rst.
- rst asserted in the 3rd cycle of toggle len=10. Required: next cycle state IDLE, J=K=0, q_model=0, no done pulse.

Source files
------------

// File: rtl/jk_pkg.sv
`timescale 1ns/1ps
// jk_pkg: shared definitions for the JK drive sequencer.
//   - JK_* op codes, encoded as {J,K}
//   - state_t and ST_* state constants for the sequencer FSM
//   - jk_next(): characteristic function of a JK flip-flop
package jk_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_DRIVE  = 2'd1;
  localparam state_t ST_SETTLE = 2'd2;

  // Next Q of a JK flip-flop, given the current Q and the {J,K} drive.
  function automatic logic jk_next(input logic q, input logic [1:0] op);
    logic n;
    case (op)
      JK_HOLD:   n = q;
      JK_RESET:  n = 1'b0;
      JK_SET:    n = 1'b1;
      default:   n = ~q;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jk_drive_sequencer.sv
`timescale 1ns/1ps
// jk_drive_sequencer: drives J/K of a downstream master-slave JK flip-flop
// with hold/reset/set/toggle commands for a programmed number of cycles,
// tracks the expected flip-flop output and checks it after the slave settles.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cmd_valid/ready   command handshake (ready only in IDLE)
//   cmd_op            {J,K} op: 00 hold, 01 reset, 10 set, 11 toggle
//   cmd_len           drive length in cycles (0 = check only)
//   J, K              registered drive to the flip-flop
//   q_in              flip-flop slave Q
//   q_model           expected Q after all completed drive cycles
//   busy              high in DRIVE or SETTLE
//   done              one-cycle pulse at command completion
//   mismatch          one-cycle pulse with done when q_in != q_model
//   err_sticky        latched mismatch, cleared only by rst
module jk_drive_sequencer
  import jk_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             J,
  output logic             K,
  input  logic             q_in,
  output logic             q_model,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic             err_sticky
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_op;
  logic [1:0]       w_op_nxt;
  logic             r_ready;
  logic             r_busy;
  logic             r_j;
  logic             r_k;
  logic             r_q;
  logic             r_done;
  logic             r_mis;
  logic             r_err;
  logic             w_accept;
  logic             w_check_bad;

  // r_ready is only ever 1 while r_state is IDLE, so it alone qualifies accept.
  assign w_accept    = r_ready & cmd_valid;
  assign w_op_nxt    = w_accept ? cmd_op : r_op;
  assign w_check_bad = (r_state == ST_SETTLE) && (q_in != r_q);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (cmd_len == '0) ? ST_SETTLE : ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        // Exit on 1 so the counter never wraps below zero.
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = ST_SETTLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_j     <= 1'b0;
      r_k     <= 1'b0;
      r_q     <= 1'b0;
      r_done  <= 1'b0;
      r_mis   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == ST_IDLE);
      r_busy  <= (w_state_nxt != ST_IDLE);

      if (w_accept) begin
        r_op  <= cmd_op;
        r_cnt <= cmd_len;
      end else if (r_state == ST_DRIVE) begin
        // Each DRIVE edge is one completed drive cycle seen by the flip-flop.
        r_cnt <= r_cnt - CNT_W'(1);
        r_q   <= jk_next(r_q, r_op);
      end

      // J/K follow the state being entered so they are valid for its whole cycle.
      {r_j, r_k} <= (w_state_nxt == ST_DRIVE) ? w_op_nxt : 2'b00;

      // The slave latch updated at the SETTLE negedge, so q_in is final here.
      r_done <= (r_state == ST_SETTLE);
      r_mis  <= w_check_bad;
      if (w_check_bad) begin
        r_err <= 1'b1;
      end
    end
  end

  assign cmd_ready  = r_ready;
  assign busy       = r_busy;
  assign J          = r_j;
  assign K          = r_k;
  assign q_model    = r_q;
  assign done       = r_done;
  assign mismatch   = r_mis;
  assign err_sticky = r_err;

endmodule

// File: tb/tb_jk_drive_sequencer.sv
`timescale 1ns/1ps
module tb_jk_drive_sequencer;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_RESET  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_len = 8'd0;
  logic       J, K;
  logic       q_in;
  logic       q_model, busy, done, mismatch, err_sticky;

  int vectors = 0;
  int miscompares = 0;

  // Downstream master-slave JK flip-flop: master samples on posedge,
  // slave follows on negedge. No reset.
  logic ff_m, ff_q;
  logic force_inv = 1'b0;

  function automatic logic ff_next(input logic q, input logic j, input logic k);
    logic n;
    if (j && k)       n = ~q;
    else if (j)       n = 1'b1;
    else if (k)       n = 1'b0;
    else              n = q;
    return n;
  endfunction

  always @(posedge clk) ff_m <= ff_next(ff_q, J, K);
  always @(negedge clk) ff_q <= ff_m;
  assign q_in = ff_q ^ force_inv;

  always #5 clk = ~clk;

  jk_drive_sequencer #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_len    (cmd_len),
    .J          (J),
    .K          (K),
    .q_in       (q_in),
    .q_model    (q_model),
    .busy       (busy),
    .done       (done),
    .mismatch   (mismatch),
    .err_sticky (err_sticky)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and check it cycle by cycle through its done pulse.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] len,
                         input logic exp_q, input logic exp_mis, input string name);
    int guard;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready_timeout: cmd_ready=%b want 1", name, cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = ~op;
    cmd_len   = 8'hFF;
    for (int i = 0; i < int'(len); i++) begin
      vectors++;
      if ({J, K} !== op || done !== 1'b0 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL %s drive[%0d]: JK=%b%b done=%b ready=%b busy=%b want JK=%b done=0 ready=0 busy=1",
                 name, i, J, K, done, cmd_ready, busy, op);
      end
      tick();
    end
    vectors++;
    if ({J, K} !== 2'b00 || done !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s settle: JK=%b%b done=%b busy=%b ready=%b want JK=00 done=0 busy=1 ready=0",
               name, J, K, done, busy, cmd_ready);
    end
    tick();
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s done_latency: done=%b want 1 at %0d edges after accept", name, done, int'(len) + 1);
    end
    vectors++;
    if (mismatch !== exp_mis) begin
      miscompares++;
      $display("FAIL %s mismatch: got %b want %b", name, mismatch, exp_mis);
    end
    vectors++;
    if (q_model !== exp_q) begin
      miscompares++;
      $display("FAIL %s q_model: got %b want %b", name, q_model, exp_q);
    end
    vectors++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || {J, K} !== 2'b00) begin
      miscompares++;
      $display("FAIL %s done_cycle: ready=%b busy=%b JK=%b%b want ready=1 busy=0 JK=00",
               name, cmd_ready, busy, J, K);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({J, K} !== 2'b00 || q_model !== 1'b0 || done !== 1'b0 || err_sticky !== 1'b0
          || cmd_ready !== 1'b0 || busy !== 1'b0 || mismatch !== 1'b0) begin
        miscompares++;
        $display("FAIL reset[%0d]: JK=%b%b q=%b done=%b err=%b ready=%b busy=%b mis=%b want all 0",
                 i, J, K, q_model, done, err_sticky, cmd_ready, busy, mismatch);
      end
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: ready=%b busy=%b want ready=1 busy=0", cmd_ready, busy);
    end
  endtask

  task automatic test_set_reset();
    run_cmd(OP_SET, 8'd1, 1'b1, 1'b0, "set1");
    // Accepted in the done cycle of the previous command.
    run_cmd(OP_RESET, 8'd2, 1'b0, 1'b0, "reset2");
  endtask

  task automatic test_toggle();
    run_cmd(OP_RESET, 8'd1, 1'b0, 1'b0, "reset1");
    run_cmd(OP_TOGGLE, 8'd5, 1'b1, 1'b0, "toggle5");
    vectors++;
    if (q_in !== 1'b1) begin
      miscompares++;
      $display("FAIL toggle5 q_in: got %b want 1", q_in);
    end
  endtask

  task automatic test_zero_len();
    run_cmd(OP_TOGGLE, 8'd0, 1'b1, 1'b0, "toggle0");
    tick();
    vectors++;
    if (done !== 1'b0 || {J, K} !== 2'b00) begin
      miscompares++;
      $display("FAIL toggle0 after: done=%b JK=%b%b want done=0 JK=00", done, J, K);
    end
  endtask

  task automatic test_mismatch();
    force_inv = 1'b1;
    run_cmd(OP_SET, 8'd3, 1'b1, 1'b1, "set3_bad");
    force_inv = 1'b0;
    vectors++;
    if (err_sticky !== 1'b1) begin
      miscompares++;
      $display("FAIL set3_bad err_sticky: got %b want 1", err_sticky);
    end
    tick();
    vectors++;
    if (mismatch !== 1'b0 || done !== 1'b0 || err_sticky !== 1'b1) begin
      miscompares++;
      $display("FAIL set3_bad pulse: mis=%b done=%b err=%b want mis=0 done=0 err=1", mismatch, done, err_sticky);
    end
    run_cmd(OP_RESET, 8'd1, 1'b0, 1'b0, "reset1_after");
    run_cmd(OP_SET, 8'd2, 1'b1, 1'b0, "set2_after");
    vectors++;
    if (err_sticky !== 1'b1) begin
      miscompares++;
      $display("FAIL err_hold: err_sticky=%b want 1", err_sticky);
    end
  endtask

  task automatic test_mid_reset();
    cmd_valid = 1'b1;
    cmd_op    = OP_TOGGLE;
    cmd_len   = 8'd10;
    tick();
    cmd_valid = 1'b0;
    vectors++;
    if ({J, K} !== 2'b11) begin
      miscompares++;
      $display("FAIL midrst drive: JK=%b%b want 11", J, K);
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({J, K} !== 2'b00 || q_model !== 1'b0 || done !== 1'b0 || busy !== 1'b0
        || cmd_ready !== 1'b0 || err_sticky !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst reset: JK=%b%b q=%b done=%b busy=%b ready=%b err=%b want all 0",
               J, K, q_model, done, busy, cmd_ready, err_sticky);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      vectors++;
      if (done !== 1'b0 || {J, K} !== 2'b00 || cmd_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL midrst idle[%0d]: done=%b JK=%b%b ready=%b want done=0 JK=00 ready=1",
                 i, done, J, K, cmd_ready);
      end
    end
    run_cmd(OP_SET, 8'd2, 1'b1, 1'b0, "set2_post");
  endtask

  initial begin
    test_reset();
    test_set_reset();
    test_toggle();
    test_zero_len();
    test_mismatch();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
